// File: rtl/dpram_pkg.sv
// Shared parameters and types for the dual-port RAM burst controller.
package dpram_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 6;
    localparam int LEN_W_DEF  = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    typedef struct packed {
        logic valid;
        logic last;
    } rd_tag_t;

endpackage

// File: rtl/dpram_burst_ctrl.sv
// Burst initiator for one port of the single-clock dual_port_ram.
// Turns burst commands plus write/read streams into cycle-accurate RAM accesses.
//
// state | meaning
// IDLE  | waiting for a command; cmd_ready high
// WRITE | accepting write words, one RAM commit per accepted word
// READ  | issuing one read address per cycle
// DRAIN | last address issued; waiting for the read-tag pipe to empty
module dpram_burst_ctrl
    import dpram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
);

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [LEN_W-1:0]  cnt;
    rd_tag_t           tag_s0;
    rd_tag_t           tag_s1;

    assign cmd_ready = (state == ST_IDLE) && !rst;
    assign wr_ready  = (state == ST_WRITE);
    assign busy      = (state != ST_IDLE) || tag_s0.valid || tag_s1.valid;

    // Stage 1 of the tag pipe lines up with the RAM's registered q.
    assign rd_valid  = tag_s1.valid;
    assign rd_last   = tag_s1.valid && tag_s1.last;
    assign rd_data   = ram_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            cnt      <= '0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_data <= '0;
            tag_s0   <= '0;
            tag_s1   <= '0;
        end else begin
            ram_we <= 1'b0;
            tag_s1 <= tag_s0;
            tag_s0 <= '0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        ptr   <= cmd_addr;
                        cnt   <= cmd_len;
                        state <= cmd_write ? ST_WRITE : ST_READ;
                    end
                end
                ST_WRITE: begin
                    if (wr_valid) begin
                        ram_we   <= 1'b1;
                        ram_addr <= ptr;
                        ram_data <= wr_data;
                        ptr      <= ptr + 1'b1;
                        cnt      <= cnt - 1'b1;
                        if (cnt == '0)
                            state <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    ram_addr <= ptr;
                    ptr      <= ptr + 1'b1;
                    cnt      <= cnt - 1'b1;
                    tag_s0   <= rd_tag_t'{valid: 1'b1, last: (cnt == '0)};
                    if (cnt == '0)
                        state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!tag_s0.valid && !tag_s1.valid)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dpram_burst_ctrl.sv
// Directed bench for dpram_burst_ctrl driving a behavioural single-port view of the RAM.
module tb_dpram_burst_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [5:0] cmd_addr = '0;
    logic [5:0] cmd_len = '0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [7:0] wr_data = '0;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_last;
    logic       busy;
    logic [7:0] ram_data;
    logic [5:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_q = '0;

    logic [7:0] mem [64];

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int ready_viol = 0;

    logic [5:0] we_addr_q [$];
    logic [7:0] we_data_q [$];
    logic [7:0] rd_data_q [$];
    logic       rd_last_q [$];
    int         rd_cyc_q  [$];

    dpram_burst_ctrl #(.DATA_W(8), .ADDR_W(6), .LEN_W(6)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
        .busy(busy),
        .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we), .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_we) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    always @(negedge clk) begin
        if (ram_we) begin
            we_addr_q.push_back(ram_addr);
            we_data_q.push_back(ram_data);
        end
        if (rd_valid) begin
            rd_data_q.push_back(rd_data);
            rd_last_q.push_back(rd_last);
            rd_cyc_q.push_back(cyc);
        end
    end

    task automatic clear_logs();
        we_addr_q.delete(); we_data_q.delete();
        rd_data_q.delete(); rd_last_q.delete(); rd_cyc_q.delete();
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic issue_cmd(input logic w, input logic [5:0] a, input logic [5:0] l, output int acc);
        int k;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
        k = 0;
        @(negedge clk);
        while (!cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!cmd_ready) begin
            n_total++;
            $display("FAIL cmd_accept_timeout: cmd_ready=%0b required 1", cmd_ready);
        end
        @(posedge clk); #1;
        acc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic send_words(input logic [7:0] d [8], input int n, input int gap);
        int k;
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b0;
            repeat (gap) begin
                @(negedge clk);
                if (cmd_ready) ready_viol++;
                @(posedge clk); #1;
            end
            wr_valid = 1'b1;
            wr_data  = d[i];
            k = 0;
            @(negedge clk);
            while (!wr_ready && k < 50) begin
                @(negedge clk);
                k++;
            end
            if (!wr_ready) begin
                n_total++;
                $display("FAIL wr_accept_timeout: wr_ready=%0b required 1", wr_ready);
            end
            if (cmd_ready) ready_viol++;
            @(posedge clk); #1;
            wr_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (busy) begin
            n_total++;
            $display("FAIL idle_timeout: busy=%0b required 0", busy);
        end
        settle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        @(negedge clk);
        n_total++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %0b want 1", cmd_ready); else n_pass++;
        n_total++; if (wr_ready !== 1'b0) $display("FAIL reset_wr_ready: got %0b want 0", wr_ready); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else n_pass++;
        n_total++; if (ram_we !== 1'b0 || ram_addr !== 6'h00 || ram_data !== 8'h00)
            $display("FAIL reset_ram_port: we=%0b addr=%h data=%h want 0/00/00", ram_we, ram_addr, ram_data); else n_pass++;
        n_total++; if (rd_valid !== 1'b0 || rd_last !== 1'b0)
            $display("FAIL reset_rd: valid=%0b last=%0b want 0/0", rd_valid, rd_last); else n_pass++;
    endtask

    task automatic test_basic();
        logic [7:0] d [8];
        logic [7:0] exp [3];
        int acc;
        exp[0] = 8'h33; exp[1] = 8'h55; exp[2] = 8'h77;
        for (int i = 0; i < 8; i++) d[i] = (i < 3) ? exp[i] : 8'h00;
        @(posedge clk); #1;
        clear_logs();
        issue_cmd(1'b1, 6'h01, 6'd2, acc);
        send_words(d, 3, 0);
        wait_idle();
        n_total++; if (we_addr_q.size() !== 3) $display("FAIL basic_we_count: got %0d want 3", we_addr_q.size()); else n_pass++;
        for (int i = 0; i < 3 && i < we_addr_q.size(); i++) begin
            n_total++;
            if (we_addr_q[i] !== 6'(1 + i) || we_data_q[i] !== exp[i])
                $display("FAIL basic_we_%0d: addr=%h data=%h want %h/%h", i, we_addr_q[i], we_data_q[i], 6'(1 + i), exp[i]);
            else n_pass++;
        end
        clear_logs();
        issue_cmd(1'b0, 6'h01, 6'd2, acc);
        wait_idle();
        n_total++; if (rd_data_q.size() !== 3) $display("FAIL basic_rd_count: got %0d want 3", rd_data_q.size()); else n_pass++;
        for (int i = 0; i < 3 && i < rd_data_q.size(); i++) begin
            n_total++;
            if (rd_data_q[i] !== exp[i] || rd_last_q[i] !== (i == 2) || rd_cyc_q[i] !== acc + 2 + i)
                $display("FAIL basic_rd_%0d: data=%h last=%0b lat=%0d want %h/%0b/%0d",
                         i, rd_data_q[i], rd_last_q[i], rd_cyc_q[i] - acc, exp[i], (i == 2), 2 + i);
            else n_pass++;
        end
        n_total++; if (we_addr_q.size() !== 0) $display("FAIL basic_rd_no_we: got %0d writes want 0", we_addr_q.size()); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [7:0] d [8];
        logic [5:0] ea [4];
        int acc;
        ea[0] = 6'h3E; ea[1] = 6'h3F; ea[2] = 6'h00; ea[3] = 6'h01;
        for (int i = 0; i < 8; i++) d[i] = 8'hA0 + 8'(i);
        clear_logs();
        issue_cmd(1'b1, 6'h3E, 6'd3, acc);
        send_words(d, 4, 0);
        wait_idle();
        n_total++; if (we_addr_q.size() !== 4) $display("FAIL wrap_we_count: got %0d want 4", we_addr_q.size()); else n_pass++;
        for (int i = 0; i < 4 && i < we_addr_q.size(); i++) begin
            n_total++;
            if (we_addr_q[i] !== ea[i] || we_data_q[i] !== d[i])
                $display("FAIL wrap_we_%0d: addr=%h data=%h want %h/%h", i, we_addr_q[i], we_data_q[i], ea[i], d[i]);
            else n_pass++;
        end
        clear_logs();
        issue_cmd(1'b0, 6'h3E, 6'd3, acc);
        wait_idle();
        n_total++; if (rd_data_q.size() !== 4) $display("FAIL wrap_rd_count: got %0d want 4", rd_data_q.size()); else n_pass++;
        for (int i = 0; i < 4 && i < rd_data_q.size(); i++) begin
            n_total++;
            if (rd_data_q[i] !== d[i] || rd_last_q[i] !== (i == 3))
                $display("FAIL wrap_rd_%0d: data=%h last=%0b want %h/%0b", i, rd_data_q[i], rd_last_q[i], d[i], (i == 3));
            else n_pass++;
        end
    endtask

    task automatic test_gapped();
        logic [7:0] d [8];
        int acc;
        for (int i = 0; i < 8; i++) d[i] = 8'h00;
        d[0] = 8'h11; d[1] = 8'h22;
        clear_logs();
        ready_viol = 0;
        issue_cmd(1'b1, 6'h10, 6'd1, acc);
        send_words(d, 2, 2);
        wait_idle();
        n_total++; if (ready_viol !== 0) $display("FAIL gap_cmd_ready_during_burst: got %0d highs want 0", ready_viol); else n_pass++;
        n_total++; if (we_addr_q.size() !== 2) $display("FAIL gap_we_count: got %0d want 2", we_addr_q.size()); else n_pass++;
        for (int i = 0; i < 2 && i < we_addr_q.size(); i++) begin
            n_total++;
            if (we_addr_q[i] !== 6'(16 + i) || we_data_q[i] !== d[i])
                $display("FAIL gap_we_%0d: addr=%h data=%h want %h/%h", i, we_addr_q[i], we_data_q[i], 6'(16 + i), d[i]);
            else n_pass++;
        end
        clear_logs();
        issue_cmd(1'b0, 6'h10, 6'd1, acc);
        wait_idle();
        n_total++;
        if (rd_data_q.size() !== 2 || rd_data_q[0] !== 8'h11 || rd_data_q[1] !== 8'h22 || rd_last_q[1] !== 1'b1)
            $display("FAIL gap_readback: count=%0d want 2 words 11,22 with last on 22", rd_data_q.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] d [8];
        int acc_w;
        int acc_r;
        for (int i = 0; i < 8; i++) d[i] = 8'h00;
        d[0] = 8'h99;
        clear_logs();
        issue_cmd(1'b1, 6'h05, 6'd0, acc_w);
        send_words(d, 1, 0);
        issue_cmd(1'b0, 6'h05, 6'd0, acc_r);
        wait_idle();
        n_total++; if (acc_r !== acc_w + 2) $display("FAIL b2b_read_accept_cycle: got +%0d want +2", acc_r - acc_w); else n_pass++;
        n_total++;
        if (rd_data_q.size() !== 1 || rd_data_q[0] !== 8'h99 || rd_last_q[0] !== 1'b1)
            $display("FAIL b2b_readback: count=%0d want 1 word 99 with last", rd_data_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] d [8];
        int acc;
        for (int i = 0; i < 8; i++) d[i] = 8'hC0 + 8'(i);
        issue_cmd(1'b1, 6'h20, 6'd7, acc);
        send_words(d, 8, 0);
        wait_idle();
        clear_logs();
        issue_cmd(1'b0, 6'h20, 6'd7, acc);
        repeat (4) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk);
        #1; rst = 1'b0;
        #1;
        n_total++; if (rd_valid !== 1'b0) $display("FAIL rstmid_rd_valid: got %0b want 0", rd_valid); else n_pass++;
        n_total++; if (cmd_ready !== 1'b1) $display("FAIL rstmid_cmd_ready: got %0b want 1", cmd_ready); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %0b want 0", busy); else n_pass++;
        repeat (10) @(posedge clk);
        #1;
        n_total++; if (rd_data_q.size() !== 3) $display("FAIL rstmid_word_count: got %0d want 3", rd_data_q.size()); else n_pass++;
        for (int i = 0; i < rd_data_q.size(); i++) begin
            n_total++;
            if (rd_last_q[i] !== 1'b0 || rd_data_q[i] !== d[i])
                $display("FAIL rstmid_word_%0d: data=%h last=%0b want %h/0", i, rd_data_q[i], rd_last_q[i], d[i]);
            else n_pass++;
        end
        n_total++; if (we_addr_q.size() !== 0) $display("FAIL rstmid_no_we: got %0d writes want 0", we_addr_q.size()); else n_pass++;
        clear_logs();
        issue_cmd(1'b0, 6'h20, 6'd7, acc);
        wait_idle();
        n_total++; if (rd_data_q.size() !== 8) $display("FAIL rstmid_reread_count: got %0d want 8", rd_data_q.size()); else n_pass++;
        for (int i = 0; i < 8 && i < rd_data_q.size(); i++) begin
            n_total++;
            if (rd_data_q[i] !== d[i] || rd_last_q[i] !== (i == 7))
                $display("FAIL rstmid_reread_%0d: data=%h last=%0b want %h/%0b", i, rd_data_q[i], rd_last_q[i], d[i], (i == 7));
            else n_pass++;
        end
    endtask

    task automatic test_ignore();
        logic [7:0] d [8];
        int acc;
        int bad;
        for (int i = 0; i < 8; i++) d[i] = 8'h00;
        d[0] = 8'h5A; d[1] = 8'hA5;
        clear_logs();
        wr_valid = 1'b1; wr_data = 8'hEE;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (wr_ready !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) bad++;
        end
        @(posedge clk); #1;
        wr_valid = 1'b0;
        settle();
        n_total++; if (bad !== 0) $display("FAIL ignore_idle_handshake: got %0d bad cycles want 0", bad); else n_pass++;
        n_total++; if (we_addr_q.size() !== 0) $display("FAIL ignore_idle_we: got %0d writes want 0", we_addr_q.size()); else n_pass++;
        issue_cmd(1'b1, 6'h30, 6'd1, acc);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 6'h08; cmd_len = 6'd3;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (cmd_ready !== 1'b0 || wr_ready !== 1'b1 || ram_we !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        n_total++; if (bad !== 0) $display("FAIL ignore_busy_cmd: got %0d bad cycles want 0", bad); else n_pass++;
        send_words(d, 2, 0);
        wait_idle();
        n_total++;
        if (we_addr_q.size() !== 2 || we_addr_q[0] !== 6'h30 || we_addr_q[1] !== 6'h31 ||
            we_data_q[0] !== 8'h5A || we_data_q[1] !== 8'hA5)
            $display("FAIL ignore_write_after_hold: count=%0d want 2 writes 30:5A 31:A5", we_addr_q.size());
        else n_pass++;
        n_total++; if (cmd_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL ignore_end_idle: cmd_ready=%0b busy=%0b want 1/0", cmd_ready, busy); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_gapped();
        test_back_to_back();
        test_reset_mid_read();
        test_ignore();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
